// File: rtl/execute_writeback.sv
// Execute/writeback stage: ALU, load/store strobes and branch resolution.
// Every output is registered, and a one-cycle bubble follows each taken branch.
module execute_writeback #(
  parameter int unsigned OPC_W = 4
) (
  input  logic       clk,
  input  logic       sync_rst,
  input  logic       in_valid,
  input  logic [7:0] opc_in,
  input  logic [1:0] dst_in,
  input  logic       has_imm,
  input  logic [7:0] data_A,
  input  logic [7:0] data_B,
  input  logic [7:0] imm_in,
  input  logic [7:0] mem_data_in,
  output logic       stall_out,
  output logic       write_en,
  output logic [1:0] addr_write,
  output logic [7:0] data_in,
  output logic       mem_read_en,
  output logic [7:0] mem_rd_addr,
  output logic       mem_write,
  output logic [7:0] mem_wr_addr,
  output logic [7:0] mem_wr_data,
  output logic [7:0] branch_wr,
  output logic       branch_wr_en,
  output logic       illegal
);

  localparam int unsigned DW = 8;
  localparam int unsigned RW = 2;

  localparam logic [OPC_W-1:0] OP_NOP = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_AND = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_OR  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_LDI = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_LD  = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_ST  = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_BZ  = OPC_W'(10);

  typedef enum logic [1:0] {EXEC, LOAD_WAIT, FLUSH} state_t;

  state_t          state_q, state_d;
  logic            carry_q, carry_d;
  logic [RW-1:0]   ld_dst_q, ld_dst_d;
  logic            stall_q, stall_d;
  logic            write_en_q, write_en_d;
  logic [RW-1:0]   addr_write_q, addr_write_d;
  logic [DW-1:0]   data_in_q, data_in_d;
  logic            mem_read_en_q, mem_read_en_d;
  logic [DW-1:0]   mem_rd_addr_q, mem_rd_addr_d;
  logic            mem_write_q, mem_write_d;
  logic [DW-1:0]   mem_wr_addr_q, mem_wr_addr_d;
  logic [DW-1:0]   mem_wr_data_q, mem_wr_data_d;
  logic [DW-1:0]   branch_wr_q, branch_wr_d;
  logic            branch_wr_en_q, branch_wr_en_d;
  logic            illegal_q, illegal_d;

  logic [OPC_W-1:0] op;
  logic [DW-1:0]    opnd_b;
  logic [DW:0]      sum;
  logic             unused_opc_lo;

  assign op            = opc_in[7 -: OPC_W];
  assign unused_opc_lo = ^opc_in[7-OPC_W:0];
  assign opnd_b        = has_imm ? imm_in : data_B;
  assign sum           = {1'b0, data_A} + {1'b0, opnd_b};

  // State and output registers
  always_ff @(posedge clk) begin
    if (!sync_rst) begin
      state_q        <= EXEC;
      carry_q        <= 1'b0;
      ld_dst_q       <= '0;
      stall_q        <= 1'b0;
      write_en_q     <= 1'b0;
      addr_write_q   <= '0;
      data_in_q      <= '0;
      mem_read_en_q  <= 1'b0;
      mem_rd_addr_q  <= '0;
      mem_write_q    <= 1'b0;
      mem_wr_addr_q  <= '0;
      mem_wr_data_q  <= '0;
      branch_wr_q    <= '0;
      branch_wr_en_q <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      carry_q        <= carry_d;
      ld_dst_q       <= ld_dst_d;
      stall_q        <= stall_d;
      write_en_q     <= write_en_d;
      addr_write_q   <= addr_write_d;
      data_in_q      <= data_in_d;
      mem_read_en_q  <= mem_read_en_d;
      mem_rd_addr_q  <= mem_rd_addr_d;
      mem_write_q    <= mem_write_d;
      mem_wr_addr_q  <= mem_wr_addr_d;
      mem_wr_data_q  <= mem_wr_data_d;
      branch_wr_q    <= branch_wr_d;
      branch_wr_en_q <= branch_wr_en_d;
      illegal_q      <= illegal_d;
    end
  end

  // Next state: strobes default low, address/data hold their last value
  always_comb begin
    state_d        = state_q;
    carry_d        = carry_q;
    ld_dst_d       = ld_dst_q;
    stall_d        = 1'b0;
    write_en_d     = 1'b0;
    addr_write_d   = addr_write_q;
    data_in_d      = data_in_q;
    mem_read_en_d  = 1'b0;
    mem_rd_addr_d  = mem_rd_addr_q;
    mem_write_d    = 1'b0;
    mem_wr_addr_d  = mem_wr_addr_q;
    mem_wr_data_d  = mem_wr_data_q;
    branch_wr_d    = branch_wr_q;
    branch_wr_en_d = 1'b0;
    illegal_d      = 1'b0;

    case (state_q)
      EXEC: begin
        if (in_valid) begin
          case (op)
            OP_NOP: ;
            OP_ADD: begin
              write_en_d   = 1'b1;
              addr_write_d = dst_in;
              data_in_d    = sum[DW-1:0];
              carry_d      = sum[DW];
            end
            OP_SUB: begin
              write_en_d   = 1'b1;
              addr_write_d = dst_in;
              data_in_d    = data_A - opnd_b;
              carry_d      = (data_A < opnd_b);
            end
            OP_AND, OP_OR, OP_XOR, OP_LDI: begin
              write_en_d   = 1'b1;
              addr_write_d = dst_in;
              data_in_d    = (op == OP_AND) ? (data_A & opnd_b) :
                             (op == OP_OR)  ? (data_A | opnd_b) :
                             (op == OP_XOR) ? (data_A ^ opnd_b) : opnd_b;
            end
            OP_LD: begin
              mem_read_en_d = 1'b1;
              mem_rd_addr_d = data_A;
              ld_dst_d      = dst_in;
              stall_d       = 1'b1;
              state_d       = LOAD_WAIT;
            end
            OP_ST: begin
              mem_write_d   = 1'b1;
              mem_wr_addr_d = data_A;
              mem_wr_data_d = opnd_b;
            end
            OP_JMP, OP_BZ: begin
              if (op == OP_JMP || data_A == '0) begin
                branch_wr_en_d = 1'b1;
                branch_wr_d    = opnd_b;
                state_d        = FLUSH;
              end
            end
            default: illegal_d = 1'b1;
          endcase
        end
      end
      // Read data is captured at the close of the wait cycle
      LOAD_WAIT: begin
        write_en_d   = 1'b1;
        addr_write_d = ld_dst_q;
        data_in_d    = mem_data_in;
        state_d      = EXEC;
      end
      FLUSH:   state_d = EXEC;
      default: state_d = EXEC;
    endcase
  end

  assign stall_out    = stall_q;
  assign write_en     = write_en_q;
  assign addr_write   = addr_write_q;
  assign data_in      = data_in_q;
  assign mem_read_en  = mem_read_en_q;
  assign mem_rd_addr  = mem_rd_addr_q;
  assign mem_write    = mem_write_q;
  assign mem_wr_addr  = mem_wr_addr_q;
  assign mem_wr_data  = mem_wr_data_q;
  assign branch_wr    = branch_wr_q;
  assign branch_wr_en = branch_wr_en_q;
  assign illegal      = illegal_q;

endmodule

// File: doc/execute_writeback.md
EXECUTE_WRITEBACK -- requirements
Module: execute_writeback

Interface
REQ-001 The block SHALL expose parameter OPC_W, default 4, the opcode field width taken from opc_in[7:4].
REQ-002 The block SHALL expose ports:
- clk  in  1  rising-edge clock
- sync_rst  in  1  synchronous reset, active-low
- in_valid  in  1  decode offers an instruction this cycle
- opc_in  in  8  decoded opcode; [7:4] op, [3:0] ignored
- dst_in  in  2  destination register
- has_imm  in  1  operand B comes from imm_in
- data_A  in  8  operand A
- data_B  in  8  operand B
- imm_in  in  8  immediate word
- mem_data_in  in  8  memory read data, valid 1 cycle after mem_read_en
- stall_out  out  1  decode holds its current instruction
- write_en  out  1  regfile write strobe
- addr_write  out  2  regfile write address
- data_in  out  8  regfile write data
- mem_read_en  out  1  memory read strobe
- mem_rd_addr  out  8  memory read address
- mem_write  out  1  memory write strobe
- mem_wr_addr  out  8  memory write address
- mem_wr_data  out  8  memory write data
- branch_wr  out  8  new PC
- branch_wr_en  out  1  PC load strobe
- illegal  out  1  one-cycle pulse on an unknown opcode
REQ-003 clk SHALL be the only clock; sync_rst SHALL be synchronous and active-low, sampled on the rising clk edge.

Function
REQ-004 An instruction SHALL be accepted at an edge where in_valid=1, stall_out=0, and the state is EXEC.
REQ-005 Operand B SHALL be imm_in when has_imm=1, otherwise data_B.
REQ-006 Opcodes ([7:4]):
- 0 NOP
- 1 ADD
- 2 SUB
- 3 AND
- 4 OR
- 5 XOR
- 6 LDI (dst=B)
- 7 LD (dst=mem[A])
- 8 ST (mem[A]=B)
- 9 JMP (pc=B)
- A BZ (pc=B if A==0)
- B-F illegal
REQ-007 Arithmetic SHALL be modulo 256. The SUB result SHALL be A-B. The carry flag SHALL be updated by ADD/SUB only: ADD carry-out; SUB borrow = (A<B).
REQ-008 All outputs SHALL be registered: for an instruction accepted at edge N, strobes are high during cycle N+1 only.
REQ-009 ALU ops and LDI SHALL assert write_en with addr_write=dst_in and data_in=result one cycle after acceptance.
REQ-010 ST SHALL assert mem_write for 1 cycle with mem_wr_addr=A and mem_wr_data=B; write_en SHALL stay 0.
REQ-011 NOP SHALL assert no strobes.
REQ-012 Illegal opcodes SHALL pulse illegal for 1 cycle, assert no other strobe, and be treated as NOP.
REQ-013 State machine states SHALL be EXEC, LOAD_WAIT, FLUSH.
REQ-014 LD accepted in EXEC SHALL transition to LOAD_WAIT:
- next cycle: mem_read_en=1, mem_rd_addr=A, stall_out=1
- following cycle: write_en=1, data_in=mem_data_in as sampled at end of LOAD_WAIT, addr_write=latched dst, stall_out=0, state returns to EXEC
REQ-015 stall_out SHALL be 1 exactly during LOAD_WAIT; in_valid SHALL be ignored there.
REQ-016 JMP, and BZ with A==0, SHALL assert branch_wr_en=1 with branch_wr=B for 1 cycle and enter FLUSH.
REQ-017 BZ with A!=0 SHALL produce no strobe and remain in EXEC.
REQ-018 FLUSH SHALL last exactly 1 cycle, discard any in_valid instruction (no strobes, no flag change), then return to EXEC.
REQ-019 Strobe outputs SHALL deassert the cycle after their pulse unless a new accepted instruction re-asserts them; back-to-back ALU ops SHALL produce write_en on consecutive cycles.
REQ-020 Address/data outputs SHALL hold their last values when their strobe is 0.

Reset
REQ-021 While sync_rst=0 at an edge, the block SHALL load:
- state = EXEC
- carry = 0
- all strobes = 0, stall_out = 0, illegal = 0
- all address/data outputs = 0
REQ-022 Reset during LOAD_WAIT or FLUSH SHALL abort the operation with no regfile write, and the first post-reset cycle SHALL accept a new instruction.
REQ-023 Reset SHALL take priority over all in-cycle events.

Verification
REQ-024 The bench SHALL check: ADD A=0xF0, B=0x20, dst=2 -> next cycle write_en=1, addr_write=2, data_in=0x10, carry=1.
REQ-025 The bench SHALL check: LD A=0x40, mem_data_in=0x5A, dst=1 -> mem_read_en=1 with mem_rd_addr=0x40 and stall_out=1 for 1 cycle, then write_en=1 with data_in=0x5A and addr_write=1.
REQ-026 The bench SHALL check: BZ A=0, imm 0x33 (has_imm=1), followed by ADD -> branch_wr_en=1 with branch_wr=0x33; the ADD in FLUSH produces no write_en.
REQ-027 The bench SHALL check: ST A=0x10, B=0x77 -> mem_write=1, mem_wr_addr=0x10, mem_wr_data=0x77, write_en=0.
REQ-028 The bench SHALL check: opcode 0xC0 -> illegal=1 for 1 cycle, no other strobe.
REQ-029 The bench SHALL check: sync_rst=0 asserted in LOAD_WAIT -> no write_en, and an LDI on the first post-reset cycle writes correctly.
